// File: rtl/riscv_alu_decoder.sv
// RV32I decode stage: instruction word -> ALUOp, operand selects, immediate.
// Single-entry valid/ready register with flush and illegal-instruction counter.
module riscv_alu_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       alu_op,
  output logic [1:0]       src_a_sel,
  output logic             src_b_imm,
  output logic [31:0]      imm,
  output logic             rd_we,
  output logic             is_branch,
  output logic             is_jump,
  output logic             mem_req,
  output logic             mem_we,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LD    = 7'b0000011;
  localparam logic [6:0] OPC_ST    = 7'b0100011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [1:0] SRC_RS1  = 2'd0;
  localparam logic [1:0] SRC_PC   = 2'd1;
  localparam logic [1:0] SRC_ZERO = 2'd2;

  typedef struct packed {
    logic [4:0]  alu;
    logic [1:0]  asel;
    logic        bimm;
    logic [31:0] imm;
    logic        rd_we;
    logic        br;
    logic        jmp;
    logic        mreq;
    logic        mwe;
    logic        ill;
  } dec_t;

  dec_t d;
  dec_t q;
  logic vld;
  logic [CNT_W-1:0] cnt;
  logic legal;
  logic accept;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opc = in_instr[6:0];
  assign f3  = in_instr[14:12];
  assign f7  = in_instr[31:25];

  assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                  in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u = {in_instr[31:12], 12'b0};
  assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                  in_instr[20], in_instr[30:21], 1'b0};

  always_comb begin
    d     = '0;
    legal = 1'b1;
    unique case (1'b1)
      opc == OPC_OP: begin
        d.alu   = {1'b0, in_instr[30], f3};
        d.rd_we = 1'b1;
        legal   = (f7 == 7'b0000000) ||
                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
      end
      opc == OPC_IMM: begin
        d.alu   = (f3 == 3'b101) ? {1'b0, in_instr[30], 3'b101}
                                 : {2'b00, f3};
        d.bimm  = 1'b1;
        d.imm   = imm_i;
        d.rd_we = 1'b1;
        if (f3 == 3'b001)
          legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101)
          legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
      end
      opc == OPC_BR: begin
        d.alu = {2'b11, f3};
        d.imm = imm_b;
        d.br  = 1'b1;
        legal = (f3 != 3'b010) && (f3 != 3'b011);
      end
      opc == OPC_LD: begin
        d.bimm  = 1'b1;
        d.imm   = imm_i;
        d.mreq  = 1'b1;
        d.rd_we = 1'b1;
      end
      opc == OPC_ST: begin
        d.bimm = 1'b1;
        d.imm  = imm_s;
        d.mreq = 1'b1;
        d.mwe  = 1'b1;
      end
      opc == OPC_LUI: begin
        d.asel  = SRC_ZERO;
        d.bimm  = 1'b1;
        d.imm   = imm_u;
        d.rd_we = 1'b1;
      end
      opc == OPC_AUIPC: begin
        d.asel  = SRC_PC;
        d.bimm  = 1'b1;
        d.imm   = imm_u;
        d.rd_we = 1'b1;
      end
      opc == OPC_JAL: begin
        d.asel  = SRC_PC;
        d.bimm  = 1'b1;
        d.imm   = imm_j;
        d.jmp   = 1'b1;
        d.rd_we = 1'b1;
      end
      opc == OPC_JALR: begin
        d.asel  = SRC_RS1;
        d.bimm  = 1'b1;
        d.imm   = imm_i;
        d.jmp   = 1'b1;
        d.rd_we = 1'b1;
        legal   = (f3 == 3'b000);
      end
      default: legal = 1'b0;
    endcase
    // Illegal words travel as a side-effect-free ADD.
    if (!legal) begin
      d     = '0;
      d.ill = 1'b1;
    end
  end

  assign in_ready = !vld || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      q   <= '0;
      cnt <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld <= 1'b1;
      q   <= d;
      if (d.ill && !(&cnt))
        cnt <= cnt + CNT_W'(1);
    end else if (out_ready) begin
      vld <= 1'b0;
    end
  end

  assign out_valid   = vld;
  assign alu_op      = q.alu;
  assign src_a_sel   = q.asel;
  assign src_b_imm   = q.bimm;
  assign imm         = q.imm;
  assign rd_we       = q.rd_we;
  assign is_branch   = q.br;
  assign is_jump     = q.jmp;
  assign mem_req     = q.mreq;
  assign mem_we      = q.mwe;
  assign illegal     = q.ill;
  assign illegal_cnt = cnt;

endmodule

// File: tb/tb_riscv_alu_decoder.sv
// Bench for riscv_alu_decoder: directed steps then randomized traffic
// against a handshake/decode reference model.
module tb_riscv_alu_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alu_op;
  logic [1:0]  src_a_sel;
  logic        src_b_imm;
  logic [31:0] imm;
  logic        rd_we, is_branch, is_jump, mem_req, mem_we, illegal;
  logic [15:0] illegal_cnt;

  logic        in_ready2, out_valid2, src_b_imm2;
  logic [4:0]  alu_op2;
  logic [1:0]  src_a_sel2;
  logic [31:0] imm2;
  logic        rd_we2, is_branch2, is_jump2, mem_req2, mem_we2, illegal2;
  logic [1:0]  illegal_cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_alu_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_op(alu_op), .src_a_sel(src_a_sel),
    .src_b_imm(src_b_imm), .imm(imm), .rd_we(rd_we),
    .is_branch(is_branch), .is_jump(is_jump), .mem_req(mem_req),
    .mem_we(mem_we), .illegal(illegal), .illegal_cnt(illegal_cnt)
  );

  riscv_alu_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_instr(in_instr), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .alu_op(alu_op2), .src_a_sel(src_a_sel2),
    .src_b_imm(src_b_imm2), .imm(imm2), .rd_we(rd_we2),
    .is_branch(is_branch2), .is_jump(is_jump2), .mem_req(mem_req2),
    .mem_we(mem_we2), .illegal(illegal2), .illegal_cnt(illegal_cnt2)
  );

  typedef struct {
    logic [4:0]  alu;
    logic [1:0]  asel;
    logic        bimm;
    logic [31:0] imm;
    logic        rd_we, br, jmp, mreq, mwe, ill;
  } exp_t;

  exp_t e;
  bit   ev;
  int   ecnt;

  function automatic exp_t ref_dec(input logic [31:0] w);
    exp_t r;
    logic [2:0] f3;
    logic [6:0] f7;
    bit ok;
    f3 = w[14:12];
    f7 = w[31:25];
    r = '{alu: 5'd0, asel: 2'd0, bimm: 1'b1, imm: 32'd0, rd_we: 1'b1,
          br: 1'b0, jmp: 1'b0, mreq: 1'b0, mwe: 1'b0, ill: 1'b0};
    ok = 1;
    case (w[6:0])
      7'h33: begin
        r.alu = {1'b0, w[30], f3}; r.bimm = 0;
        ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
      end
      7'h13: begin
        r.alu = {2'b00, f3};
        if (f3 == 5) r.alu = {1'b0, w[30], 3'b101};
        r.imm = 32'($signed(w) >>> 20);
        if (f3 == 1) ok = (f7 == 0);
        if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20);
      end
      7'h63: begin
        r.alu = {2'b11, f3}; r.bimm = 0; r.rd_we = 0; r.br = 1;
        r.imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 20'd0}) >>> 19);
        ok = (f3 != 2) && (f3 != 3);
      end
      7'h03: begin
        r.imm = 32'($signed(w) >>> 20); r.mreq = 1;
      end
      7'h23: begin
        r.imm = 32'($signed({w[31:25], w[11:7], 20'd0}) >>> 20);
        r.mreq = 1; r.mwe = 1; r.rd_we = 0;
      end
      7'h37: begin r.asel = 2; r.imm = w & 32'hFFFFF000; end
      7'h17: begin r.asel = 1; r.imm = w & 32'hFFFFF000; end
      7'h6F: begin
        r.asel = 1; r.jmp = 1;
        r.imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 12'd0}) >>> 11);
      end
      7'h67: begin
        r.imm = 32'($signed(w) >>> 20); r.jmp = 1; ok = (f3 == 0);
      end
      default: ok = 0;
    endcase
    if (!ok) begin
      r.ill = 1; r.alu = 0; r.rd_we = 0; r.br = 0;
      r.jmp = 0; r.mreq = 0; r.mwe = 0;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    int c16, c2;
    c16 = (ecnt > 65535) ? 65535 : ecnt;
    c2  = (ecnt > 3) ? 3 : ecnt;
    chk("in_ready", 32'(in_ready), 32'(!ev || out_ready));
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("cnt", 32'(illegal_cnt), 32'(c16));
    chk("cnt_sat", 32'(illegal_cnt2), 32'(c2));
    if (ev) begin
      chk("illegal", 32'(illegal), 32'(e.ill));
      chk("alu_op", 32'(alu_op), 32'(e.alu));
      chk("flags", {27'd0, rd_we, is_branch, is_jump, mem_req, mem_we},
          {27'd0, e.rd_we, e.br, e.jmp, e.mreq, e.mwe});
      if (!e.ill) begin
        chk("src_a_sel", 32'(src_a_sel), 32'(e.asel));
        chk("src_b_imm", 32'(src_b_imm), 32'(e.bimm));
        chk("imm", imm, e.imm);
      end
    end
  endtask

  task automatic cycle();
    bit rdy;
    rdy = !ev || out_ready;
    if (flush) ev = 0;
    else if (in_valid && rdy) begin
      ev = 1;
      e = ref_dec(in_instr);
      if (e.ill) ecnt++;
    end else if (out_ready) ev = 0;
    @(posedge clk);
    #1;
    chk_model();
  endtask

  task automatic chk_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_src", {29'd0, src_a_sel, src_b_imm}, 32'd0);
    chk("rst_imm", imm, 32'd0);
    chk("rst_flags", {26'd0, rd_we, is_branch, is_jump, mem_req, mem_we,
        illegal}, 32'd0);
    chk("rst_cnt", 32'(illegal_cnt), 32'd0);
    chk("rst_cnt2", 32'(illegal_cnt2), 32'd0);
  endtask

  function automatic logic [31:0] gen();
    logic [31:0] w;
    logic [6:0] opcs [9];
    opcs = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67};
    w = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      w[6:0] = opcs[$urandom_range(0, 8)];
      case ($urandom_range(0, 3))
        0: w[31:25] = 7'h00;
        1: w[31:25] = {1'b0, 1'b1, 5'd0};
        default: ;
      endcase
      if (w[6:0] == 7'h67 && $urandom_range(0, 1) == 1) w[14:12] = 3'd0;
    end
    return w;
  endfunction

  initial begin
    rst_n = 0; in_valid = 0; in_instr = 0; flush = 0; out_ready = 1;
    ev = 0; ecnt = 0;
    #12;
    chk_reset();
    @(negedge clk);
    rst_n = 1;

    // back-to-back add then sub
    in_valid = 1; in_instr = 32'h002081B3;
    cycle();
    chk("add_op", 32'(alu_op), 32'h00);
    in_instr = 32'h402081B3;
    cycle();
    chk("sub_op", 32'(alu_op), 32'h08);
    chk("sub_vld", 32'(out_valid), 32'd1);
    chk("sub_rdwe", 32'(rd_we), 32'd1);
    chk("sub_bimm", 32'(src_b_imm), 32'd0);

    in_instr = 32'h40335293;
    cycle();
    chk("srai_op", 32'(alu_op), 32'h0D);
    chk("srai_imm", imm, 32'h403);
    chk("srai_bimm", 32'(src_b_imm), 32'd1);

    in_instr = 32'hFE20ECE3;
    cycle();
    chk("bltu_op", 32'(alu_op), 32'h1E);
    chk("bltu_br", 32'(is_branch), 32'd1);
    chk("bltu_imm", imm, 32'hFFFFFFF8);
    chk("bltu_rdwe", 32'(rd_we), 32'd0);

    // backpressure
    in_instr = 32'hFFF00093;
    cycle();
    chk("addi_imm", imm, 32'hFFFFFFFF);
    out_ready = 0; in_instr = 32'h40335293;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("bp_ready", 32'(in_ready), 32'd0);
      chk("bp_hold", imm, 32'hFFFFFFFF);
    end
    out_ready = 1;
    cycle();
    chk("bp_take", imm, 32'h403);

    // illegal words and saturation
    in_instr = 32'h00000073;
    cycle();
    chk("ill1", 32'(illegal), 32'd1);
    chk("ill1_cnt", 32'(illegal_cnt), 32'd1);
    in_instr = 32'h0020A0E3;
    cycle();
    chk("ill2_op", 32'(alu_op), 32'd0);
    chk("ill2_cnt", 32'(illegal_cnt), 32'd2);
    in_instr = 32'h00000073;
    for (int i = 0; i < 3; i++) cycle();
    chk("sat_cnt", 32'(illegal_cnt2), 32'd3);
    chk("full_cnt", 32'(illegal_cnt), 32'd5);

    // flush with a simultaneous accept of an illegal word
    flush = 1;
    cycle();
    chk("flush_vld", 32'(out_valid), 32'd0);
    chk("flush_cnt", 32'(illegal_cnt), 32'd5);
    flush = 0;

    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_instr  = gen();
      cycle();
    end

    // async reset while an entry is held
    flush = 0; in_valid = 1; out_ready = 0; in_instr = 32'h002081B3;
    cycle();
    cycle();
    #2;
    rst_n = 0;
    #1;
    chk_reset();
    ev = 0; ecnt = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1; in_instr = 32'h40335293;
    cycle();
    chk("post_rst_op", 32'(alu_op), 32'h0D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
